// File: rtl/instr_encoder_writer.sv
// Packs decoded RV32I fields into instruction words and streams them to instruction memory.
// Latency: one cycle from handshake to mem_we/mem_wdata; optional IMM_RANGE_CHECK_EN adds immediate checks.
// Backpressure: in_ready drops when the FIFO is full and not popping, or when not in RUN; writes hold while mem_ready=0.

module sync_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DW-1:0]            push_dat,
    input  logic                     pop,
    output logic [DW-1:0]            head_dat,
    output logic                     head_vld,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign head_vld = (cnt != '0);
    assign full     = (cnt == (AW+1)'(DEPTH));
endmodule

module instr_encoder_writer #(
    parameter int                    DEPTH      = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  prog_start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [2:0]            in_fmt,
    input  logic [6:0]            in_opcode,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [31:0]           in_imm,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    output logic                  done,
    output logic                  err
);
    localparam int          CW  = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  err_q;
    logic [31:0]           enc;
    logic                  bad;
    logic                  push, pop;
    logic [31:0]           fifo_head;
    logic                  fifo_vld, fifo_full;
    logic [CW-1:0]         fifo_cnt;

    always_comb begin
        enc = NOP;
        bad = 1'b0;
        case (in_fmt)
            3'd0: enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            3'd1: enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            3'd2: enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            3'd3: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_opcode};
            3'd4: enc = {in_imm[31:12], in_rd, in_opcode};
            3'd5: enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            default: bad = 1'b1;
        endcase
`ifdef IMM_RANGE_CHECK_EN
        case (in_fmt)
            3'd1, 3'd2: if ($signed(in_imm) < -32'sd2048 || $signed(in_imm) > 32'sd2047) bad = 1'b1;
            3'd3: if ($signed(in_imm) < -32'sd4096 || $signed(in_imm) > 32'sd4094 || in_imm[0]) bad = 1'b1;
            3'd4: if (in_imm[11:0] != 12'd0) bad = 1'b1;
            3'd5: if ($signed(in_imm) < -32'sd1048576 || $signed(in_imm) > 32'sd1048574 || in_imm[0]) bad = 1'b1;
            default: ;
        endcase
`endif
        if (bad) enc = NOP;
    end

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign pop      = fifo_vld & mem_ready;
    assign in_ready = (state_q == RUN) && (!fifo_full || pop);
    assign push     = in_valid & in_ready;

    sync_fifo #(.DW(32), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (prog_start),
        .push     (push),
        .push_dat (enc),
        .pop      (pop),
        .head_dat (fifo_head),
        .head_vld (fifo_vld),
        .full     (fifo_full),
        .cnt      (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= BASE_ADDR;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (prog_start) begin
                addr_q <= BASE_ADDR;
                err_q  <= 1'b0;
            end else begin
                if (pop)        addr_q <= addr_q + ADDR_WIDTH'(4);
                if (push && bad) err_q <= 1'b1;
            end
        end
    end

    // DONE is entered on the edge of the final pop so done rises the cycle after it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = IDLE;
            RUN:   if (push && in_last) state_d = DRAIN;
            DRAIN: if (!fifo_vld || (pop && fifo_cnt == CW'(1))) state_d = DONE;
            DONE:  state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (prog_start) state_d = RUN;
    end

    assign mem_we    = fifo_vld;
    assign mem_addr  = addr_q;
    assign mem_wdata = fifo_vld ? fifo_head : 32'h0;
    assign done      = (state_q == DONE);
    assign err       = err_q;
endmodule

// File: tb/tb_instr_encoder_writer.sv
// Directed and randomized bench for instr_encoder_writer against a field-packing reference model.
module tb_instr_encoder_writer;
    logic        clk = 1'b0;
    logic        rst_n, prog_start, in_valid, in_ready, in_last;
    logic [2:0]  in_fmt, in_funct3;
    logic [6:0]  in_opcode, in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, mem_addr, mem_wdata;
    logic        mem_we, mem_ready, done, err;

    always #5 clk = ~clk;

    instr_encoder_writer #(.DEPTH(4), .ADDR_WIDTH(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .prog_start(prog_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .done(done), .err(err)
    );

    int          n_checks = 0, n_pass = 0, n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr = 32'h0;
    logic        exp_err  = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] hold_addr, hold_data;
    logic [31:0] f_fmt, f_op, f_f3, f_f7, f_rd, f_rs1, f_rs2, f_imm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: place each field at its bit position with shifts and masks.
    function automatic logic [31:0] ref_enc(output logic bad);
        logic [31:0] r;
        int          s;
        s   = int'($signed(f_imm));
        bad = 1'b0;
        r   = 32'h13;
        case (f_fmt)
            0: r = (f_f7 << 25) | (f_rs2 << 20) | (f_rs1 << 15) | (f_f3 << 12) | (f_rd << 7) | f_op;
            1: r = ((f_imm & 32'hfff) << 20) | (f_rs1 << 15) | (f_f3 << 12) | (f_rd << 7) | f_op;
            2: r = (((f_imm >> 5) & 32'h7f) << 25) | (f_rs2 << 20) | (f_rs1 << 15) | (f_f3 << 12)
                   | ((f_imm & 32'h1f) << 7) | f_op;
            3: r = (((f_imm >> 12) & 32'h1) << 31) | (((f_imm >> 5) & 32'h3f) << 25) | (f_rs2 << 20)
                   | (f_rs1 << 15) | (f_f3 << 12) | (((f_imm >> 1) & 32'hf) << 8)
                   | (((f_imm >> 11) & 32'h1) << 7) | f_op;
            4: r = (f_imm & 32'hfffff000) | (f_rd << 7) | f_op;
            5: r = (((f_imm >> 20) & 32'h1) << 31) | (((f_imm >> 1) & 32'h3ff) << 21)
                   | (((f_imm >> 11) & 32'h1) << 20) | (((f_imm >> 12) & 32'hff) << 12) | (f_rd << 7) | f_op;
            default: bad = 1'b1;
        endcase
`ifdef IMM_RANGE_CHECK_EN
        case (f_fmt)
            1, 2: if (s < -2048 || s > 2047) bad = 1'b1;
            3: if (s < -4096 || s > 4094 || f_imm[0]) bad = 1'b1;
            4: if (f_imm[11:0] != 12'd0) bad = 1'b1;
            5: if (s < -(1 << 20) || s > (1 << 20) - 2 || f_imm[0]) bad = 1'b1;
            default: ;
        endcase
`else
        if (s == 0) bad = bad;
`endif
        if (bad) r = 32'h13;
        return r;
    endfunction

    task automatic set_fields(input int fmt, op, f3, f7, rd, rs1, rs2, input logic [31:0] imm);
        f_fmt = fmt; f_op = op; f_f3 = f3; f_f7 = f7;
        f_rd = rd; f_rs1 = rs1; f_rs2 = rs2; f_imm = imm;
    endtask

    task automatic rand_fields(input bit allow_bad);
        logic [31:0] imm;
        imm = $urandom_range(0, 1) ? $urandom : ($urandom_range(0, 8191) - 32'd4096);
        set_fields(allow_bad ? $urandom_range(0, 7) : $urandom_range(0, 5), $urandom_range(0, 127),
                   $urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31),
                   $urandom_range(0, 31), $urandom_range(0, 31), imm);
    endtask

    task automatic drive_fields(input logic last);
        in_valid  = 1'b1;          in_last   = last;
        in_fmt    = f_fmt[2:0];    in_opcode = f_op[6:0];
        in_funct3 = f_f3[2:0];     in_funct7 = f_f7[6:0];
        in_rd     = f_rd[4:0];     in_rs1    = f_rs1[4:0];
        in_rs2    = f_rs2[4:0];    in_imm    = f_imm;
    endtask

    task automatic send(input logic last, input bit rnd);
        logic        bad;
        logic [31:0] e;
        bit          got = 1'b0;
        @(posedge clk); #1;
        drive_fields(last);
        e = ref_enc(bad);
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                exp_q.push_back(e);
                exp_err = exp_err | bad;
            end
            @(posedge clk); #1;
            if (rnd) mem_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("handshake_done", 32'(got), 32'd1);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        mem_ready = 1'b1;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (!mem_we && exp_q.size() == 0) ok = 1'b1;
        end
        chk("drain_done", 32'(ok), 32'd1);
    endtask

    task automatic prog();
        @(posedge clk); #1;
        prog_start = 1'b1;
        exp_q.delete();
        exp_addr = 32'h0;
        exp_err  = 1'b0;
        @(posedge clk); #1;
        prog_start = 1'b0;
    endtask

    // Write-side scoreboard: every accepted write must match the next expected word and address.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (prev_stall) begin
                chk("hold_addr", mem_addr, hold_addr);
                chk("hold_data", mem_wdata, hold_data);
            end
            if (mem_ready) begin
                chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    chk("write_data", mem_wdata, exp_q.pop_front());
                    chk("write_addr", mem_addr, exp_addr);
                    exp_addr = exp_addr + 32'd4;
                end
            end
        end
        prev_stall = rst_n && mem_we && !mem_ready;
        hold_addr  = mem_addr;
        hold_data  = mem_wdata;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic        bad;
        logic [31:0] e;
        rst_n = 1'b0; prog_start = 1'b0; mem_ready = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_fmt = '0; in_opcode = '0; in_funct3 = '0;
        in_funct7 = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;

        // Reset values
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        prog();
        mem_ready = 1'b1;
        @(negedge clk);
        chk("run_in_ready", 32'(in_ready), 32'd1);

        // I / B / S / J directed words
        set_fields(1, 7'h13, 0, 0, 1, 0, 0, 32'd5);
        send(1'b0, 1'b0);
        @(negedge clk);
        chk("i_mem_we", 32'(mem_we), 32'd1);
        chk("i_addr", mem_addr, 32'h0);
        chk("i_data", mem_wdata, 32'h0050_0093);
        set_fields(3, 7'h63, 1, 0, 0, 1, 0, -32'sd4);
        send(1'b0, 1'b0);
        set_fields(2, 7'h23, 2, 0, 0, 1, 2, 32'd12);
        send(1'b0, 1'b0);
        @(negedge clk);
        chk("s_addr", mem_addr, 32'h8);
        chk("s_data", mem_wdata, 32'h0020_A623);
        set_fields(5, 7'h6f, 0, 0, 1, 0, 0, 32'd8);
        send(1'b1, 1'b0);
        @(negedge clk);
        chk("j_addr", mem_addr, 32'hC);
        chk("j_data", mem_wdata, 32'h0080_00EF);
        @(negedge clk);
        chk("j_done", 32'(done), 32'd1);
        chk("j_in_ready", 32'(in_ready), 32'd0);
        chk("j_mem_we", 32'(mem_we), 32'd0);
        drain();

        // Fill under stall, then push while full and popping
        prog();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_fields(1'b0);
            send(1'b0, 1'b0);
        end
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_addr", mem_addr, 32'h0);
        chk("full_data", mem_wdata, exp_q[0]);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        rand_fields(1'b0);
        drive_fields(1'b0);
        e = ref_enc(bad);
        @(negedge clk);
        chk("full_pop_in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(e);
        exp_err = exp_err | bad;
        @(posedge clk); #1 in_valid = 1'b0;
        drain();
        chk("full_end_addr", mem_addr, 32'h14);

        // Invalid format queues NOP and sets sticky err
        prog();
        set_fields(7, 7'h33, 0, 0, 3, 4, 5, 32'd0);
        send(1'b0, 1'b0);
        @(negedge clk);
        chk("inv_data", mem_wdata, 32'h13);
        chk("inv_err", 32'(err), 32'd1);
        set_fields(1, 7'h13, 0, 0, 1, 0, 0, 32'd5);
        send(1'b0, 1'b0);
        drain();
        chk("inv_err_sticky", 32'(err), 32'd1);
`ifdef IMM_RANGE_CHECK_EN
        prog();
        set_fields(1, 7'h13, 0, 0, 1, 0, 0, 32'd4096);
        send(1'b0, 1'b0);
        @(negedge clk);
        chk("range_data", mem_wdata, 32'h13);
        chk("range_err", 32'(err), 32'd1);
        drain();
`endif
        prog();
        @(negedge clk);
        chk("err_cleared", 32'(err), 32'd0);

        // Randomized program with random memory stalls
        for (int i = 0; i < 40; i++) begin
            rand_fields(1'b1);
            send(i == 39, 1'b1);
        end
        drain();
        chk("rnd_err", 32'(err), 32'(exp_err));
        chk("rnd_done", 32'(done), 32'd1);
        chk("rnd_end_addr", mem_addr, 32'd160);

        // Reset with entries queued
        prog();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_fields(1'b0);
            send(1'b0, 1'b0);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        exp_addr = 32'h0;
        @(negedge clk);
        chk("mrst_mem_we", 32'(mem_we), 32'd0);
        chk("mrst_addr", mem_addr, 32'h0);
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        chk("mrst_wdata", mem_wdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_mem_we", 32'(mem_we), 32'd0);
        chk("post_rst_idle", 32'(in_ready), 32'd0);
        prog();
        set_fields(4, 7'h37, 0, 0, 5, 0, 0, 32'h1234_5000);
        send(1'b0, 1'b0);
        @(negedge clk);
        chk("post_rst_addr", mem_addr, 32'h0);
        chk("post_rst_data", mem_wdata, 32'h1234_52B7);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/instr_encoder_writer.md
Name: instr_encoder_writer

Overview:
- Inverse of the core's instruction decoder. Accepts decoded instruction fields (format, opcode, funct3/funct7, register indices, immediate) over a valid/ready handshake and packs them into RV32I instruction words.
- Buffers the encoded words in a small FIFO.
- Writes them sequentially into instruction memory from a programmable base address.
- Used by testbenches and boot logic to load programs without a hex file.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- ADDR_WIDTH, 32, instruction memory address width.
- BASE_ADDR, 32'h0, first write address after prog_start.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- prog_start  in  1  pulse: reload address counter, clear done/err, enter RUN.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept (FIFO not full and state RUN).
- in_last  in  1  marks final instruction of program.
- in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 invalid.
- in_opcode  in  7  opcode field.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7 (R only).
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  signed immediate (byte offset for B/J; upper value already <<12 for U).
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_WIDTH  word address (byte-addressed, step 4).
- mem_wdata  out  32  encoded instruction.
- mem_ready  in  1  memory accepts write this cycle.
- done  out  1  high from last write until next prog_start.
- err  out  1  sticky error flag.

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, done=0, err=0, FIFO empty, state IDLE.
- States:
  - IDLE: in_ready=0. prog_start → RUN.
  - RUN: accepts entries. Handshake in_valid&in_ready with in_last=1 → DRAIN.
  - DRAIN: in_ready=0. FIFO empty → DONE.
  - DONE: done=1. prog_start → RUN.
  - prog_start in any state → RUN, with FIFO flushed, address=BASE_ADDR, done=0, err=0.
- Encoding: combinational from inputs, registered into the FIFO on handshake.
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - Unused fields are ignored.
- Invalid fmt (6/7): the entry is accepted, 32'h00000013 (NOP) is queued, and err is set.
- Write side:
  - mem_we=1 whenever the FIFO is non-empty; mem_wdata = FIFO head; mem_addr = current counter.
  - Pop on mem_we&mem_ready; the counter advances by 4 and wraps modulo 2^ADDR_WIDTH.
  - mem_we, mem_addr and mem_wdata stay stable while mem_ready=0.
- Latency: an accepted entry can appear on mem_wdata the next cycle (minimum 1 cycle).
- FIFO boundaries:
  - Simultaneous push and pop when full is allowed, so in_ready stays high.
  - Simultaneous push and pop when empty: the entry is written on the following cycle.
- done rises in the cycle after the last pop.
- rst_n asserted mid-operation: immediate return to reset values, with FIFO contents discarded.

Optional Feature:
- IMM_RANGE_CHECK_EN defined: a range/alignment check runs on handshake. A failing entry queues a NOP and sets err. Checks:
  - I/S: imm within [-2048, 2047].
  - B: imm within [-4096, 4094] and imm[0]=0.
  - J: imm within [-2^20, 2^20-2] and imm[0]=0.
  - U: imm[11:0]=0.
- Undefined: the immediate is silently truncated per the field slices above; only invalid fmt sets err.

Test Plan:
- prog_start, I fmt opcode 0010011 rd=1 rs1=0 f3=0 imm=5, mem_ready=1 → mem_we at addr 0x0, wdata 0x00500093.
- B fmt opcode 1100011 f3=001 rs1=1 rs2=0 imm=-4 → 0xFE009EE3. Then S fmt opcode 0100011 f3=010 rs1=1 rs2=2 imm=12 → 0x0020A623 at next address +4.
- J fmt opcode 1101111 rd=1 imm=8 with in_last=1 → 0x008000EF written; done=1 the cycle after, in_ready=0.
- mem_ready=0, push 4 entries (DEPTH=4) → in_ready=0 after the 4th, and mem_addr/mem_wdata are held. Release mem_ready → 4 writes at 0x0,0x4,0x8,0xC.
- in_fmt=7 → 0x00000013 written, err=1 until next prog_start. With IMM_RANGE_CHECK_EN: I imm=4096 → NOP and err=1.
- Assert rst_n=0 while 3 entries are queued → mem_we=0, FIFO empty, mem_addr=BASE_ADDR, state IDLE; no writes until prog_start.
